// File: rtl/datapath_pkg.sv
// Shared definitions for the execute datapath: sizes, opcode class codes,
// ALU and PC sub-op encodings, flag bit positions and full opcode bytes.
package datapath_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NUM_REGS   = 8;
  localparam int RAM_DEPTH  = 256;
  localparam int REG_IDX_W  = $clog2(NUM_REGS);
  localparam int RAM_ADDR_W = $clog2(RAM_DEPTH);
  localparam int FLAG_W     = 4;

  // Opcode class codes, opcode[15:12]
  localparam logic [3:0] CLS_ALU = 4'h1;
  localparam logic [3:0] CLS_REG = 4'h2;
  localparam logic [3:0] CLS_RAM = 4'h4;
  localparam logic [3:0] CLS_PC  = 4'h7;

  // Full opcode bytes, opcode[15:8]
  localparam logic [7:0] OP_REG_LOAD   = 8'h21;
  localparam logic [7:0] OP_REG_READ   = 8'h22;
  localparam logic [7:0] OP_RAM_WR_IMM = 8'h41;
  localparam logic [7:0] OP_RAM_READ   = 8'h42;
  localparam logic [7:0] OP_RAM_WR_BUS = 8'h43;

  // ALU sub-ops, opcode[11:8]; ALU_MUL only executes when ALU_MUL_EN is defined
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOT = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_MOV = 4'd8,
    ALU_MUL = 4'd9
  } alu_op_e;

  // PC sub-ops, opcode[11:8]
  typedef enum logic [3:0] {
    PC_JMP = 4'd0,
    PC_JZ  = 4'd1,
    PC_JNZ = 4'd2,
    PC_JC  = 4'd3
  } pc_op_e;

  // Flag bit positions within {V,N,C,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: result and {V,N,C,Z} flags from sub-op and two operands.
// valid_o is low for undefined sub-ops so the caller skips the write.
// Optional multiplier: define ALU_MUL_EN to enable sub-op 9 (MUL).
module dp_alu
  import datapath_pkg::*;
(
  input  logic [3:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic [FLAG_W-1:0]     flags_o,
  output logic                  valid_o
);

  localparam int W = DATA_WIDTH;

  logic [W:0] wide;
  logic       carry;
  logic       ovf;
`ifdef ALU_MUL_EN
  logic [2*W-1:0] prod;
`endif

  // Compute result, carry/borrow/shift-out and signed overflow per sub-op
  always_comb begin
    result_o = '0;
    wide     = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    valid_o  = 1'b1;
`ifdef ALU_MUL_EN
    prod     = '0;
`endif
    case (op_i)
      ALU_ADD: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[W-1:0];
        carry    = wide[W];
        ovf      = (a_i[W-1] == b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
      end
      ALU_SUB: begin
        // Bit W of the widened difference is the borrow
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[W-1:0];
        carry    = wide[W];
        ovf      = (a_i[W-1] != b_i[W-1]) && (result_o[W-1] != a_i[W-1]);
      end
      ALU_AND: result_o = a_i & b_i;
      ALU_OR:  result_o = a_i | b_i;
      ALU_XOR: result_o = a_i ^ b_i;
      ALU_NOT: result_o = ~a_i;
      ALU_SHL: begin
        result_o = {a_i[W-2:0], 1'b0};
        carry    = a_i[W-1];
      end
      ALU_SHR: begin
        result_o = {1'b0, a_i[W-1:1]};
        carry    = a_i[0];
      end
      ALU_MOV: result_o = a_i;
`ifdef ALU_MUL_EN
      ALU_MUL: begin
        prod     = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};
        result_o = prod[W-1:0];
        carry    = |prod[2*W-1:W];
      end
`endif
      default: valid_o = 1'b0;
    endcase
  end

  // Pack flags; Z and N always follow the result
  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_N] = result_o[W-1];
    flags_o[FLAG_C] = carry;
    flags_o[FLAG_V] = ovf;
  end

endmodule

// File: rtl/exec_datapath_core.sv
// Execute datapath: 8x16 register file, ALU with flags, program counter and
// 256-word data RAM, with a single registered read-result bus.
// Optional feature macro: ALU_MUL_EN (adds ALU sub-op 9 = MUL inside dp_alu).
//
// Handshake: each *_enable is a one-cycle strobe sampled at the rising edge;
// there is no backpressure. A read accepted at edge N drives data_out and
// raises data_valid for exactly the cycle after edge N. Register and RAM reads
// are accepted for any opcode of their own class (so a write opcode plus a read
// enable returns the pre-write word); the PC read needs no opcode.
module exec_datapath_core
  import datapath_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           opcode,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  alu_write_enable,
  input  logic                  alu_read_enable,
  input  logic                  ram_write_enable,
  input  logic                  ram_read_enable,
  input  logic                  pc_read_enable,
  input  logic                  pc_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [FLAG_W-1:0]     flags,
  output logic [DATA_WIDTH-1:0] pc
);

  // Architectural state
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] ram_q  [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] pc_q,       pc_d;
  logic [FLAG_W-1:0]     flags_q;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q,    valid_d;

  // Opcode fields
  logic [3:0]            op_cls;
  logic [3:0]            op_sub;
  logic [7:0]            op_byte;
  logic [REG_IDX_W-1:0]  rd_idx, rs1_idx, rs2_idx, bus_idx;
  logic [RAM_ADDR_W-1:0] ram_addr;

  assign op_cls   = opcode[15:12];
  assign op_sub   = opcode[11:8];
  assign op_byte  = opcode[15:8];
  assign rd_idx   = opcode[6:4];
  assign rs1_idx  = opcode[2:0];
  assign rs2_idx  = operand[REG_IDX_W-1:0];
  assign bus_idx  = operand[REG_IDX_W-1:0];
  assign ram_addr = opcode[RAM_ADDR_W-1:0];

  // ALU
  logic [DATA_WIDTH-1:0] alu_result;
  logic [FLAG_W-1:0]     alu_flags;
  logic                  alu_valid;

  dp_alu u_alu (
    .op_i     (op_sub),
    .a_i      (regs_q[rs1_idx]),
    .b_i      (regs_q[rs2_idx]),
    .result_o (alu_result),
    .flags_o  (alu_flags),
    .valid_o  (alu_valid)
  );

  // Operation qualifiers: each enable only acts on its matching opcode class
  logic alu_exec, reg_load, ram_wr_imm, ram_wr_bus;
  logic reg_rd, ram_rd, pc_rd;
  logic branch_taken;

  assign alu_exec   = alu_write_enable && (op_cls == CLS_ALU) && alu_valid;
  assign reg_load   = alu_write_enable && (op_byte == OP_REG_LOAD);
  assign ram_wr_imm = ram_write_enable && (op_byte == OP_RAM_WR_IMM);
  assign ram_wr_bus = ram_write_enable && (op_byte == OP_RAM_WR_BUS);
  assign reg_rd     = alu_read_enable &&
                      ((op_byte == OP_REG_READ) || (op_byte == OP_REG_LOAD));
  assign ram_rd     = ram_read_enable &&
                      ((op_byte == OP_RAM_READ) || (op_byte == OP_RAM_WR_IMM) ||
                       (op_byte == OP_RAM_WR_BUS));
  assign pc_rd      = pc_read_enable;

  // Branch condition evaluated on the flags held before this edge
  always_comb begin
    branch_taken = 1'b0;
    if (op_cls == CLS_PC) begin
      case (op_sub)
        PC_JMP:  branch_taken = 1'b1;
        PC_JZ:   branch_taken = flags_q[FLAG_Z];
        PC_JNZ:  branch_taken = !flags_q[FLAG_Z];
        PC_JC:   branch_taken = flags_q[FLAG_C];
        default: branch_taken = 1'b0;
      endcase
    end
  end

  // Next PC: jump target when taken, else increment with natural wrap
  always_comb begin
    pc_d = pc_q;
    if (pc_enable) begin
      pc_d = branch_taken ? operand : (pc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1});
    end
  end

  // Read mux with priority register > RAM > PC; bus holds when idle
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    if (reg_rd) begin
      data_out_d = regs_q[bus_idx];
      valid_d    = 1'b1;
    end else if (ram_rd) begin
      data_out_d = ram_q[ram_addr];
      valid_d    = 1'b1;
    end else if (pc_rd) begin
      data_out_d = pc_q;
      valid_d    = 1'b1;
    end
  end

  // Register file: ALU result or bus load (classes are exclusive)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (alu_exec) begin
      regs_q[rd_idx] <= alu_result;
    end else if (reg_load) begin
      regs_q[bus_idx] <= data_in;
    end
  end

  // Data RAM: immediate or bus write data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_DEPTH; i++) ram_q[i] <= '0;
    end else if (ram_wr_imm) begin
      ram_q[ram_addr] <= operand;
    end else if (ram_wr_bus) begin
      ram_q[ram_addr] <= data_in;
    end
  end

  // Flags update only on a defined ALU operation
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
    end else if (alu_exec) begin
      flags_q <= alu_flags;
    end
  end

  // PC, read bus and valid strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign flags      = flags_q;
  assign pc         = pc_q;

endmodule

// File: tb/tb_exec_datapath_core.sv
// Directed testbench for exec_datapath_core. Inputs change 1 ns after the
// rising edge; outputs are checked at that same point, after the edge.
module tb_exec_datapath_core;

  logic        clk;
  logic        reset;
  logic [15:0] opcode, operand, data_in;
  logic        alu_write_enable, alu_read_enable, ram_write_enable;
  logic        ram_read_enable, pc_read_enable, pc_enable;
  logic [15:0] data_out;
  logic        data_valid;
  logic [3:0]  flags;
  logic [15:0] pc;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Enable bit masks: {aw, ar, rw, rr, pr, pe}
  localparam logic [5:0] EN_NONE = 6'b000000;
  localparam logic [5:0] EN_AW   = 6'b100000;
  localparam logic [5:0] EN_AR   = 6'b010000;
  localparam logic [5:0] EN_RW   = 6'b001000;
  localparam logic [5:0] EN_RR   = 6'b000100;
  localparam logic [5:0] EN_PR   = 6'b000010;
  localparam logic [5:0] EN_PE   = 6'b000001;

  exec_datapath_core dut (
    .clk              (clk),
    .reset            (reset),
    .opcode           (opcode),
    .operand          (operand),
    .data_in          (data_in),
    .alu_write_enable (alu_write_enable),
    .alu_read_enable  (alu_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_read_enable  (ram_read_enable),
    .pc_read_enable   (pc_read_enable),
    .pc_enable        (pc_enable),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .flags            (flags),
    .pc               (pc)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: apply one cycle of stimulus, then return 1 ns after the edge
  task automatic cyc(input logic [15:0] op, input logic [15:0] opd,
                     input logic [15:0] din, input logic [5:0] en);
    opcode           = op;
    operand          = opd;
    data_in          = din;
    alu_write_enable = en[5];
    alu_read_enable  = en[4];
    ram_write_enable = en[3];
    ram_read_enable  = en[2];
    pc_read_enable   = en[1];
    pc_enable        = en[0];
    @(posedge clk);
    #1;
    alu_write_enable = 1'b0;
    alu_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    ram_read_enable  = 1'b0;
    pc_read_enable   = 1'b0;
    pc_enable        = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    opcode = '0; operand = '0; data_in = '0;
    alu_write_enable = 0; alu_read_enable = 0; ram_write_enable = 0;
    ram_read_enable = 0; pc_read_enable = 0; pc_enable = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    vec_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (flags !== 4'h0) begin err_cnt++; $display("FAIL reset_flags got=%h exp=0", flags); end
    vec_cnt++; if (pc !== 16'h0000) begin err_cnt++; $display("FAIL reset_pc got=%h exp=0000", pc); end
  endtask

  task automatic test_alu;
    cyc(16'h2100, 16'h0001, 16'hFFFF, EN_AW);   // r1 = FFFF
    cyc(16'h2100, 16'h0002, 16'h0001, EN_AW);   // r2 = 0001
    cyc(16'h1031, 16'h0002, 16'h0000, EN_AW);   // r3 = r1 + r2
    vec_cnt++; if (flags !== 4'b0011) begin err_cnt++; $display("FAIL add_wrap_flags got=%b exp=0011", flags); end
    cyc(16'h2200, 16'h0003, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL add_wrap_r3 got=%h exp=0000", data_out); end
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL reg_read_valid got=%b exp=1", data_valid); end
    cyc(16'h1032, 16'h0002, 16'h0000, EN_AW);   // r3 = r2 + r2
    vec_cnt++; if (flags !== 4'b0000) begin err_cnt++; $display("FAIL add_small_flags got=%b exp=0000", flags); end
    cyc(16'h2200, 16'h0003, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'h0002) begin err_cnt++; $display("FAIL add_small_r3 got=%h exp=0002", data_out); end
    cyc(16'h1142, 16'h0001, 16'h0000, EN_AW);   // r4 = r2 - r1 (borrow)
    vec_cnt++; if (flags !== 4'b0010) begin err_cnt++; $display("FAIL sub_flags got=%b exp=0010", flags); end
    cyc(16'h2200, 16'h0004, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'h0002) begin err_cnt++; $display("FAIL sub_r4 got=%h exp=0002", data_out); end
    cyc(16'h2100, 16'h0005, 16'h7FFF, EN_AW);   // r5 = 7FFF
    cyc(16'h1065, 16'h0002, 16'h0000, EN_AW);   // r6 = r5 + r2, overflow
    vec_cnt++; if (flags !== 4'b1100) begin err_cnt++; $display("FAIL add_ovf_flags got=%b exp=1100", flags); end
    cyc(16'h2200, 16'h0006, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'h8000) begin err_cnt++; $display("FAIL add_ovf_r6 got=%h exp=8000", data_out); end
    cyc(16'h1671, 16'h0000, 16'h0000, EN_AW);   // r7 = r1 << 1
    vec_cnt++; if (flags !== 4'b0110) begin err_cnt++; $display("FAIL shl_flags got=%b exp=0110", flags); end
    cyc(16'h2200, 16'h0007, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'hFFFE) begin err_cnt++; $display("FAIL shl_r7 got=%h exp=FFFE", data_out); end
    cyc(16'h1772, 16'h0000, 16'h0000, EN_AW);   // r7 = r2 >> 1
    vec_cnt++; if (flags !== 4'b0011) begin err_cnt++; $display("FAIL shr_flags got=%b exp=0011", flags); end
    cyc(16'h1A61, 16'h0000, 16'h0000, EN_AW);   // undefined sub-op 10
    vec_cnt++; if (flags !== 4'b0011) begin err_cnt++; $display("FAIL undef_flags got=%b exp=0011", flags); end
    cyc(16'h2200, 16'h0006, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'h8000) begin err_cnt++; $display("FAIL undef_r6 got=%h exp=8000", data_out); end
  endtask

  task automatic test_ram;
    cyc(16'h4105, 16'hBEEF, 16'h0000, EN_RW);
    cyc(16'h4205, 16'h0000, 16'h0000, EN_RR);
    vec_cnt++; if (data_out !== 16'hBEEF) begin err_cnt++; $display("FAIL ram_read got=%h exp=BEEF", data_out); end
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL ram_valid got=%b exp=1", data_valid); end
    cyc(16'h0000, 16'h0000, 16'h0000, EN_NONE);
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL ram_valid_drop got=%b exp=0", data_valid); end
    vec_cnt++; if (data_out !== 16'hBEEF) begin err_cnt++; $display("FAIL ram_hold got=%h exp=BEEF", data_out); end
    cyc(16'h4305, 16'h0000, 16'h1234, EN_RW | EN_RR);  // write + read same word
    vec_cnt++; if (data_out !== 16'hBEEF) begin err_cnt++; $display("FAIL ram_rw_old got=%h exp=BEEF", data_out); end
    cyc(16'h2105, 16'h0000, 16'h0000, EN_RW);          // wrong class, ignored
    cyc(16'h4205, 16'h0000, 16'h0000, EN_RR);
    vec_cnt++; if (data_out !== 16'h1234) begin err_cnt++; $display("FAIL ram_bus_write got=%h exp=1234", data_out); end
  endtask

  task automatic test_pc;
    cyc(16'h7000, 16'hFFFF, 16'h0000, EN_PE);          // JMP FFFF
    vec_cnt++; if (pc !== 16'hFFFF) begin err_cnt++; $display("FAIL jmp got=%h exp=FFFF", pc); end
    cyc(16'h1000, 16'h0000, 16'h0000, EN_PE);          // non-PC opcode, wrap
    vec_cnt++; if (pc !== 16'h0000) begin err_cnt++; $display("FAIL pc_wrap got=%h exp=0000", pc); end
    cyc(16'h2100, 16'h0000, 16'h0000, EN_AW);          // r0 = 0
    cyc(16'h1000, 16'h0000, 16'h0000, EN_AW);          // r0 = r0 + r0 -> Z
    cyc(16'h7100, 16'h0040, 16'h0000, EN_PE);          // JZ taken
    vec_cnt++; if (pc !== 16'h0040) begin err_cnt++; $display("FAIL jz_taken got=%h exp=0040", pc); end
    cyc(16'h2100, 16'h0002, 16'h0001, EN_AW);          // r2 = 1
    cyc(16'h1022, 16'h0002, 16'h0000, EN_AW);          // r2 = 2, flags 0
    cyc(16'h7100, 16'h0040, 16'h0000, EN_PE);          // JZ not taken
    vec_cnt++; if (pc !== 16'h0041) begin err_cnt++; $display("FAIL jz_not_taken got=%h exp=0041", pc); end
    cyc(16'h7200, 16'h0080, 16'h0000, EN_PE);          // JNZ taken
    vec_cnt++; if (pc !== 16'h0080) begin err_cnt++; $display("FAIL jnz got=%h exp=0080", pc); end
    cyc(16'h7300, 16'h0010, 16'h0000, EN_PE);          // JC not taken
    vec_cnt++; if (pc !== 16'h0081) begin err_cnt++; $display("FAIL jc_not_taken got=%h exp=0081", pc); end
    cyc(16'h7000, 16'h0200, 16'h0000, EN_PE | EN_PR);  // read old PC while jumping
    vec_cnt++; if (data_out !== 16'h0081) begin err_cnt++; $display("FAIL pc_read_old got=%h exp=0081", data_out); end
    vec_cnt++; if (pc !== 16'h0200) begin err_cnt++; $display("FAIL pc_after_read got=%h exp=0200", pc); end
  endtask

  task automatic test_read_priority;
    cyc(16'h2100, 16'h0004, 16'h4444, EN_AW);          // r4 = 4444
    cyc(16'h4104, 16'h5555, 16'h0000, EN_RW);          // RAM[4] = 5555
    cyc(16'h2204, 16'h0004, 16'h0000, EN_AR | EN_RR | EN_PR);
    vec_cnt++; if (data_out !== 16'h4444) begin err_cnt++; $display("FAIL prio_reg got=%h exp=4444", data_out); end
    cyc(16'h4204, 16'h0004, 16'h0000, EN_AR | EN_RR | EN_PR);
    vec_cnt++; if (data_out !== 16'h5555) begin err_cnt++; $display("FAIL prio_ram got=%h exp=5555", data_out); end
    cyc(16'h0000, 16'h0000, 16'h0000, EN_AR | EN_RR | EN_PR);
    vec_cnt++; if (data_out !== 16'h0200) begin err_cnt++; $display("FAIL prio_pc got=%h exp=0200", data_out); end
    cyc(16'h2100, 16'h0004, 16'hAAAA, EN_AW | EN_AR);  // write + read r4
    vec_cnt++; if (data_out !== 16'h4444) begin err_cnt++; $display("FAIL reg_rw_old got=%h exp=4444", data_out); end
    cyc(16'h2200, 16'h0004, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'hAAAA) begin err_cnt++; $display("FAIL reg_rw_new got=%h exp=AAAA", data_out); end
  endtask

  task automatic test_mul;
    logic [15:0] exp_r3;
    logic [3:0]  exp_flags;
`ifdef ALU_MUL_EN
    exp_r3    = 16'h0000;
    exp_flags = 4'b0011;
`else
    exp_r3    = 16'h3333;
    exp_flags = 4'b0000;
`endif
    cyc(16'h2100, 16'h0001, 16'h0100, EN_AW);
    cyc(16'h2100, 16'h0002, 16'h0100, EN_AW);
    cyc(16'h2100, 16'h0003, 16'h3333, EN_AW);
    cyc(16'h1931, 16'h0002, 16'h0000, EN_AW);          // sub-op 9
    vec_cnt++; if (flags !== exp_flags) begin err_cnt++; $display("FAIL mul_flags got=%b exp=%b", flags, exp_flags); end
    cyc(16'h2200, 16'h0003, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== exp_r3) begin err_cnt++; $display("FAIL mul_r3 got=%h exp=%h", data_out, exp_r3); end
  endtask

  task automatic test_reset_mid;
    cyc(16'h1000, 16'h0000, 16'h0000, EN_AW);          // r0 = 0 -> Z, C=0
    cyc(16'h2200, 16'h0004, 16'h0000, EN_AR);          // data_out = AAAA, valid
    opcode = 16'h4105; operand = 16'h9999; ram_write_enable = 1'b1;
    reset = 1'b0;
    #2;
    vec_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL rst_mid_data got=%h exp=0000", data_out); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (flags !== 4'h0) begin err_cnt++; $display("FAIL rst_mid_flags got=%h exp=0", flags); end
    vec_cnt++; if (pc !== 16'h0000) begin err_cnt++; $display("FAIL rst_mid_pc got=%h exp=0000", pc); end
    @(posedge clk);
    #1;
    ram_write_enable = 1'b0;
    reset = 1'b1;
    cyc(16'h2200, 16'h0004, 16'h0000, EN_AR);
    vec_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL rst_mid_r4 got=%h exp=0000", data_out); end
    cyc(16'h4205, 16'h0000, 16'h0000, EN_RR);
    vec_cnt++; if (data_out !== 16'h0000) begin err_cnt++; $display("FAIL rst_mid_ram got=%h exp=0000", data_out); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ram();
    test_pc();
    test_read_priority();
    test_mul();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
